// File: rtl/serial_compare_scheduler.sv
// rtl/serial_compare_scheduler.sv - round-robin front end for a shared bit-serial magnitude comparator
//
// Two requesters share one LSB-first serial comparator. A request is granted
// from IDLE, its operands are latched, WIDTH bits are shifted through the
// comparator, and a one-hot {GT,EQ,LT} result tagged with the owner ID is
// reported with a one-cycle done pulse.
//
// Optional feature macro: SERIAL_CMP_SIGNED_EN (two's complement operands).
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   req0, req1         level-sensitive comparison requests
//   a0, b0, a1, b1     operands of requester 0 / requester 1
//   gnt0, gnt1         one-cycle grant pulse, operands latched on previous edge
//   busy               high while SHIFT or DONE
//   done               one-cycle pulse, result/result_id valid
//   result             {GT,EQ,LT}, held until the next done
//   result_id          requester that owns result

module serial_compare_scheduler #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             done,
  output logic [2:0]       result,
  output logic             result_id
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] REL_GT = 3'b100;
  localparam logic [2:0] REL_EQ = 3'b010;
  localparam logic [2:0] REL_LT = 3'b001;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [2:0]       rel_q, rel_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             done_q, done_d;
  logic [2:0]       result_q, result_d;
  logic             rid_q, rid_d;
  logic             id_q, id_d;
  logic             last_q, last_d;

  logic             win_id;
  logic             last_bit;
  logic             bit_gt;
  logic             bit_lt;
  logic [2:0]       rel_next;

  // Contested requests go to whoever was not served last; otherwise the
  // single requester wins (req1 alone selects ID 1, req0 alone selects ID 0).
  assign win_id = (req0 && req1) ? ~last_q : req1;

  // Per-bit decision. The counter reaching zero marks the MSB, which is the
  // sign bit in signed mode, where its weight is negative and the roles swap.
  always_comb begin
    last_bit = (cnt_q == '0);
`ifdef SERIAL_CMP_SIGNED_EN
    if (last_bit) begin
      bit_gt = ~sa_q[0] & sb_q[0];
      bit_lt = sa_q[0] & ~sb_q[0];
    end else begin
      bit_gt = sa_q[0] & ~sb_q[0];
      bit_lt = ~sa_q[0] & sb_q[0];
    end
`else
    bit_gt = sa_q[0] & ~sb_q[0];
    bit_lt = ~sa_q[0] & sb_q[0];
`endif
    if (bit_gt) begin
      rel_next = REL_GT;
    end else if (bit_lt) begin
      rel_next = REL_LT;
    end else begin
      rel_next = rel_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    rel_d    = rel_q;
    cnt_d    = cnt_q;
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    done_d   = 1'b0;
    result_d = result_q;
    rid_d    = rid_q;
    id_d     = id_q;
    last_d   = last_q;

    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          sa_d    = win_id ? a1 : a0;
          sb_d    = win_id ? b1 : b0;
          rel_d   = REL_EQ;
          cnt_d   = CW'(WIDTH - 1);
          gnt0_d  = ~win_id;
          gnt1_d  = win_id;
          id_d    = win_id;
          last_d  = win_id;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        sa_d  = {1'b0, sa_q[WIDTH-1:1]};
        sb_d  = {1'b0, sb_q[WIDTH-1:1]};
        rel_d = rel_next;
        if (last_bit) begin
          result_d = rel_next;
          rid_d    = id_q;
          done_d   = 1'b1;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      rel_q    <= REL_EQ;
      cnt_q    <= '0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 3'b000;
      rid_q    <= 1'b0;
      id_q     <= 1'b0;
      last_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      rel_q    <= rel_d;
      cnt_q    <= cnt_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      done_q   <= done_d;
      result_q <= result_d;
      rid_q    <= rid_d;
      id_q     <= id_d;
      last_q   <= last_d;
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign done      = done_q;
  assign result    = result_q;
  assign result_id = rid_q;
  assign busy      = (state_q == S_SHIFT) || (state_q == S_DONE);

endmodule

// File: tb/tb_serial_compare_scheduler.sv
// tb/tb_serial_compare_scheduler.sv - self-checking bench for serial_compare_scheduler
module tb_serial_compare_scheduler;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0, req1;
  logic [W-1:0] a0, b0, a1, b1;
  logic         gnt0, gnt1, busy, done;
  logic [2:0]   result;
  logic         result_id;

  int n_chk  = 0;
  int n_fail = 0;
  logic model_last;
  logic mon_en = 1'b0;

  serial_compare_scheduler #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done),
    .result(result), .result_id(result_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         r0;
    logic         r1;
    logic [W-1:0] a0;
    logic [W-1:0] b0;
    logic [W-1:0] a1;
    logic [W-1:0] b1;
    logic         exp_id;
    logic [2:0]   exp_res;
  } vec_t;

`ifdef SERIAL_CMP_SIGNED_EN
  localparam logic [2:0] SIGN_EXP = 3'b001;
`else
  localparam logic [2:0] SIGN_EXP = 3'b100;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference comparison from plain integer arithmetic.
  function automatic logic [2:0] model_cmp(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SERIAL_CMP_SIGNED_EN
    if ($signed(a) > $signed(b)) return 3'b100;
    if ($signed(a) < $signed(b)) return 3'b001;
`else
    if (a > b) return 3'b100;
    if (a < b) return 3'b001;
`endif
    return 3'b010;
  endfunction

  // Protocol invariants checked on every cycle outside reset.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      chk("gnt_exclusive", 32'(gnt0 & gnt1), 32'd0);
      chk("done_gnt_exclusive", 32'(done & (gnt0 | gnt1)), 32'd0);
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_last = 1'b1;
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with it idle.
  task automatic compare_one(input string tag, input logic r0v, input logic r1v,
                             input logic [W-1:0] a0v, input logic [W-1:0] b0v,
                             input logic [W-1:0] a1v, input logic [W-1:0] b1v,
                             input logic exp_id, input logic [2:0] exp_res);
    int n;
    req0 = r0v; req1 = r1v;
    a0 = a0v; b0 = b0v; a1 = a1v; b1 = b1v;
    @(negedge clk);
    chk({tag, "_gnt"}, 32'({gnt1, gnt0}), 32'({exp_id, ~exp_id}));
    chk({tag, "_busy_hi"}, 32'(busy), 32'd1);
    req0 = 1'b0; req1 = 1'b0;
    a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
    n = 0;
    while (n < W + 5) begin
      @(negedge clk);
      n++;
      if (done) break;
    end
    chk({tag, "_latency"}, 32'(n), 32'(W));
    chk({tag, "_result"}, 32'(result), 32'(exp_res));
    chk({tag, "_id"}, 32'(result_id), 32'(exp_id));
    @(negedge clk);
    chk({tag, "_hold"}, 32'({result, result_id, busy, done}), 32'({exp_res, exp_id, 1'b0, 1'b0}));
    model_last = exp_id;
  endtask

  vec_t vecs[6];

  initial begin
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    model_last = 1'b1;
    #1;
    chk("reset_outputs", 32'({gnt0, gnt1, busy, done, result, result_id}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;

    // Directed vectors.
    vecs[0] = '{1'b1, 1'b0, 32'hB42D8C3D, 32'hB42D8C3D, 32'h0, 32'h0, 1'b0, 3'b010};
    vecs[1] = '{1'b1, 1'b0, 32'h942D8C2C, 32'h9E2D8C3D, 32'h0, 32'h0, 1'b0, 3'b001};
    vecs[2] = '{1'b0, 1'b1, 32'h0, 32'h0, 32'h00000001, 32'h00000000, 1'b1, 3'b100};
    vecs[3] = '{1'b1, 1'b0, 32'h80000000, 32'h7FFFFFFF, 32'h0, 32'h0, 1'b0, SIGN_EXP};
    vecs[4] = '{1'b1, 1'b1, 32'h1, 32'h2, 32'h00000005, 32'h00000009, 1'b1, 3'b001};
    vecs[5] = '{1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h0, 32'h1, 1'b0, 3'b100};
    for (int i = 0; i < 6; i++) begin
      compare_one($sformatf("vec%0d", i), vecs[i].r0, vecs[i].r1, vecs[i].a0, vecs[i].b0,
                  vecs[i].a1, vecs[i].b1, vecs[i].exp_id, vecs[i].exp_res);
    end

    // Contention: both held for three comparisons after a reset.
    begin
      int c, ng, nd;
      logic gid[4];
      logic did[4];
      logic [2:0] dres[4];
      int dt[4];
      do_reset();
      req0 = 1'b1; req1 = 1'b1;
      a0 = 32'd3; b0 = 32'd3; a1 = 32'd2; b1 = 32'd7;
      c = 0; ng = 0; nd = 0;
      while (c < 3 * (W + 2) + 20 && nd < 3) begin
        @(negedge clk);
        c++;
        if ((gnt0 || gnt1) && ng < 4) begin gid[ng] = gnt1; ng++; end
        if (done) begin dt[nd] = c; did[nd] = result_id; dres[nd] = result; nd++; end
      end
      req0 = 1'b0; req1 = 1'b0;
      chk("cont_ngrants", 32'(ng), 32'd3);
      chk("cont_ndone", 32'(nd), 32'd3);
      if (ng == 3 && nd == 3) begin
        chk("cont_order", 32'({gid[0], gid[1], gid[2]}), 32'(3'b010));
        chk("cont_ids", 32'({did[0], did[1], did[2]}), 32'(3'b010));
        chk("cont_first_done", 32'(dt[0]), 32'(W + 1));
        chk("cont_gap1", 32'(dt[1] - dt[0]), 32'(W + 2));
        chk("cont_gap2", 32'(dt[2] - dt[1]), 32'(W + 2));
        chk("cont_res0", 32'(dres[0]), 32'(model_cmp(32'd3, 32'd3)));
        chk("cont_res1", 32'(dres[1]), 32'(model_cmp(32'd2, 32'd7)));
      end
      @(negedge clk);
      model_last = 1'b0;
    end

    // Reset in the middle of SHIFT.
    begin
      int ndone;
      req0 = 1'b1; a0 = 32'h12345678; b0 = 32'h12345679;
      @(negedge clk);
      chk("rst_pre_gnt", 32'(gnt0), 32'd1);
      req0 = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_mid_outputs", 32'({gnt0, gnt1, busy, done, result, result_id}), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      model_last = 1'b1;
      ndone = 0;
      repeat (40) begin
        @(negedge clk);
        if (done || busy) ndone++;
      end
      chk("rst_no_done", 32'(ndone), 32'd0);
      // last_id must be back at 1, so requester 0 wins this contest.
      compare_one("post_rst", 1'b1, 1'b1, 32'hC0000000, 32'hBFFFFFFF, 32'h5, 32'h5,
                  1'b0, model_cmp(32'hC0000000, 32'hBFFFFFFF));
    end

    // Randomized comparisons against the reference model.
    for (int k = 0; k < 20; k++) begin
      logic [1:0] r;
      logic [W-1:0] ra0, rb0, ra1, rb1;
      logic eid;
      r = 2'($urandom_range(1, 3));
      ra0 = $urandom; ra1 = $urandom;
      case ($urandom_range(0, 2))
        0: begin rb0 = ra0; rb1 = ra1; end
        1: begin rb0 = ra0 ^ (32'd1 << $urandom_range(0, W - 1)); rb1 = ra1 ^ (32'd1 << $urandom_range(0, W - 1)); end
        default: begin rb0 = $urandom; rb1 = $urandom; end
      endcase
      eid = (r[0] && r[1]) ? ~model_last : r[1];
      compare_one($sformatf("rand%0d", k), r[0], r[1], ra0, rb0, ra1, rb1, eid,
                  eid ? model_cmp(ra1, rb1) : model_cmp(ra0, rb0));
    end

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_compare_scheduler.md
# serial_compare_scheduler

Shares one bit-serial unsigned magnitude comparator between two requesters. The block arbitrates round-robin, loads the granted pair of operands into internal shift registers, and shifts them LSB-first for WIDTH cycles. It then reports a one-hot {GT,EQ,LT} result tagged with the requester ID. It sits in front of the serial comparator datapath and replaces hand-sequenced load/OP driving with a start/grant/done handshake.

## Interface
- WIDTH, 32, operand width in bits; legal values are WIDTH >= 2.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req0, req1  input  1 each  comparison request from requester 0 or 1; level-sensitive.
- a0, b0, a1, b1  input  WIDTH each  operands of requester 0 and requester 1.
- gnt0, gnt1  output  1 each  one-cycle pulse; the requester's operands were latched on the preceding edge.
- busy  output  1  high while the state is SHIFT or DONE.
- done  output  1  one-cycle pulse; result and result_id are valid.
- result  output  3  {GT,EQ,LT} for a compared to b; one-hot; registered; holds until the next done.
- result_id  output  1  requester that owns result.

## Operation
- The FSM has three states: IDLE, SHIFT and DONE.
- IDLE, no request: stay in IDLE.
- IDLE with req0 or req1 set, on a clock edge:
  - the arbiter picks a winner;
  - the winner's a and b are latched into shift registers sa and sb;
  - rel is set to EQ;
  - the bit counter is set to WIDTH-1;
  - the winner's gnt is set for one cycle;
  - the FSM moves to SHIFT.
- Arbitration:
  - only one request pending: grant it;
  - both pending: grant the requester that was not granted last (last_id);
  - last_id resets to 1, so requester 0 wins the first contest.
- SHIFT, each edge: compare bit ai=sa[0] with bi=sb[0], shift sa and sb right by one, decrement the counter.
  - ai=1, bi=0: rel becomes GT.
  - ai=0, bi=1: rel becomes LT.
  - ai=bi: rel is unchanged.
  - LSB-first, so the most significant differing bit decides the result.
- SHIFT ends on the edge that processes the counter-0 bit (bit WIDTH-1). On that edge result <= final rel, result_id <= granted ID, done <= 1, and the FSM moves to DONE.
- DONE: the next edge returns the FSM to IDLE. Requests are not sampled in DONE.
- Requesters must hold req and operands stable until their gnt is seen. Operand changes after the latch edge have no effect.
- A req still high after its own done counts as a new request and competes under round-robin.
- gnt0 and gnt1 are never high together. done and gnt are never high in the same cycle.

## Timing
- Reset values: gnt0=0, gnt1=0, busy=0, done=0, result=3'b000, result_id=0, state=IDLE, last_id=1.
- Reset in mid-operation, any state: all registers return to reset values immediately. Any comparison in flight is dropped; no done is issued for it.
- Latency: with the grant edge as cycle 0, gnt is high in cycle 1 and done is high in cycle WIDTH+1.
- Throughput: one comparison per WIDTH+2 cycles under continuous requests.
- busy rises with gnt and falls with done.
- The bit counter is $clog2(WIDTH) bits wide. The counter decrement never wraps inside SHIFT.

## Configuration
- Macro: SERIAL_CMP_SIGNED_EN.
- Defined: operands are two's complement. On the final bit (sign bit), the roles are reversed: ai=1, bi=0 gives LT and ai=0, bi=1 gives GT. All other bits behave as in unsigned mode.
- Undefined: purely unsigned comparison.
- Latency, handshake and ports are identical in both modes.

## Test plan
- Equal: req0 with a0=b0=0xB42D8C3D, WIDTH=32. Expect gnt0 in cycle 1, then done in cycle 33 with result=3'b010 and result_id=0.
- Less-than at a high bit: a0=0x942D8C2C, b0=0x9E2D8C3D. Expect result=3'b001.
- LSB-only difference: a1=0x00000001, b1=0x00000000. Expect result=3'b100, result_id=1.
- Contention: req0 and req1 held high for three comparisons. Expect grant order 0,1,0, done pulses 34 cycles apart, and result_id following the same order.
- Reset mid-SHIFT: assert rst 10 cycles after gnt0. Expect all outputs at reset values immediately, no done, and a fresh request after reset completes normally.
- Sign mode: a0=0x80000000, b0=0x7FFFFFFF. Expect 3'b100 without SERIAL_CMP_SIGNED_EN and 3'b001 with it.
